// File: rtl/serializador_enable.sv
// Parallel-in, serial-out transmitter: MSB first, DIV clocks per bit, frozen while enable=0.
// First bit appears the cycle after accept; in_ready stays low from accept until the block is back in IDLE.
module serializador_enable #(
    parameter int N   = 16,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] D,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         sdata,
    output logic         bit_tick,
    output logic         frame,
    output logic         done
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]    state_q,   state_d;
    logic [N-1:0]  shreg_q,   shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          div_wrap;

    assign div_wrap = (div_cnt_q == DIV_LAST);

    assign in_ready = (state_q == ST_IDLE) & enable;
    assign frame    = (state_q == ST_SHIFT);
    assign sdata    = frame & shreg_q[N-1];
    assign bit_tick = frame & enable & div_wrap;
    assign done     = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg_d   = D;
                        bit_cnt_d = BIT_LAST;
                        div_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!div_wrap) begin
                        div_cnt_d = div_cnt_q + DW'(1);
                    end else begin
                        div_cnt_d = '0;
                        shreg_d   = {shreg_q[N-2:0], 1'b0};
                        // bit_cnt counts remaining bits after the current one
                        if (bit_cnt_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q - BW'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_serializador_enable.sv
// Bench for serializador_enable: cycle vector tables on an N=8/DIV=2 instance plus a
// receiver-side bit scoreboard, and a hand-written DIV=1/N=16 sequence.
module tb_serializador_enable;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, en8, vld8;
    logic [7:0] d8;
    logic       rdy8, sd8, tk8, fr8, dn8;

    logic        rst16, en16, vld16;
    logic [15:0] d16;
    logic        rdy16, sd16, tk16, fr16, dn16;

    serializador_enable #(.N(8), .DIV(2)) u_dut8 (
        .clk(clk), .reset(rst8), .enable(en8), .D(d8), .in_valid(vld8),
        .in_ready(rdy8), .sdata(sd8), .bit_tick(tk8), .frame(fr8), .done(dn8)
    );

    serializador_enable #(.N(16), .DIV(1)) u_dut16 (
        .clk(clk), .reset(rst16), .enable(en16), .D(d16), .in_valid(vld16),
        .in_ready(rdy16), .sdata(sd16), .bit_tick(tk16), .frame(fr16), .done(dn16)
    );

    typedef struct {
        logic       rst, en, vld;
        logic [7:0] d;
        logic       rdy, frm, sd, tk, dn;
    } vec_t;

    vec_t vecs[$];
    logic sb[$];
    int   acc_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic void check(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endfunction

    function automatic void check_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endfunction

    function automatic void add(input logic rst, input logic en, input logic vld, input logic [7:0] d,
                                input logic rdy, input logic frm, input logic sd, input logic tk,
                                input logic dn);
        vec_t v;
        v.rst = rst; v.en = en; v.vld = vld; v.d = d;
        v.rdy = rdy; v.frm = frm; v.sd = sd; v.tk = tk; v.dn = dn;
        vecs.push_back(v);
    endfunction

    // 16 SHIFT cycles plus the DONE cycle of an undisturbed DIV=2 frame
    function automatic void add_frame(input logic [7:0] w, input logic vld, input logic [7:0] d_hold);
        for (int c = 1; c <= 16; c++) begin
            add(1'b0, 1'b1, vld, vld ? d_hold : 8'(c * 29),
                1'b0, 1'b1, w[7 - (c - 1) / 2], (c % 2) == 0, 1'b0);
        end
        add(1'b0, 1'b1, vld, d_hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic run_vecs(input string tag);
        vec_t v;
        logic b;
        acc_cyc.delete();
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            rst8 = v.rst; en8 = v.en; vld8 = v.vld; d8 = v.d;
            #1;
            check($sformatf("%s[%0d].in_ready", tag, i), rdy8, v.rdy);
            check($sformatf("%s[%0d].frame", tag, i), fr8, v.frm);
            check($sformatf("%s[%0d].sdata", tag, i), sd8, v.sd);
            check($sformatf("%s[%0d].bit_tick", tag, i), tk8, v.tk);
            check($sformatf("%s[%0d].done", tag, i), dn8, v.dn);
            if (v.rst) begin
                sb.delete();
            end else if (en8) begin
                if (vld8 && rdy8) begin
                    acc_cyc.push_back(cyc);
                    for (int k = 7; k >= 0; k--) sb.push_back(d8[k]);
                end
                if (tk8) begin
                    if (sb.size() == 0) begin
                        check_int($sformatf("%s[%0d].sb_underflow", tag, i), 1, 0);
                    end else begin
                        b = sb.pop_front();
                        check($sformatf("%s[%0d].sb_bit", tag, i), sd8, b);
                    end
                end
                if (dn8) check_int($sformatf("%s[%0d].sb_left_at_done", tag, i), sb.size(), 0);
            end
            cyc++;
        end
        vecs.delete();
    endtask

    initial begin
        logic [15:0] pat;
        rst8 = 1'b1; en8 = 1'b1; vld8 = 1'b0; d8 = 8'h00;
        rst16 = 1'b1; en16 = 1'b1; vld16 = 1'b0; d16 = 16'h0000;
        repeat (2) @(negedge clk);

        // reset together with in_valid, then the plain A5 frame
        add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(8'hA5, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vecs("plain");

        // enable low for 3 cycles inside the 4th bit
        add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            if (c >= 8 && c <= 10) begin
                add(1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                int ce;
                logic [7:0] w;
                w  = 8'hA5;
                ce = (c <= 7) ? c : c - 3;
                add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, w[7 - (ce - 1) / 2], (ce % 2) == 0, 1'b0);
            end
        end
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vecs("stall");

        // reset during the 3rd bit, then a 3C frame
        add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(8'h3C, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vecs("midreset");

        // in_valid held with 3C while A5 is in flight
        add(1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(8'hA5, 1'b1, 8'h3C);
        add(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_frame(8'h3C, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vecs("b2b");
        check_int("b2b.accept_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check_int("b2b.accept_spacing", acc_cyc[1] - acc_cyc[0], 18);

        // DIV=1, N=16: one bit per cycle, D changed mid-frame
        pat = 16'h8001;
        @(negedge clk);
        rst16 = 1'b0;
        #1;
        check("w16.idle_ready", rdy16, 1'b1);
        check("w16.idle_frame", fr16, 1'b0);
        vld16 = 1'b1; d16 = pat;
        @(negedge clk);
        vld16 = 1'b0; d16 = 16'h7FFE;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("w16.sdata[%0d]", i), sd16, pat[15 - i]);
            check($sformatf("w16.tick[%0d]", i), tk16, 1'b1);
            check($sformatf("w16.frame[%0d]", i), fr16, 1'b1);
            check($sformatf("w16.ready[%0d]", i), rdy16, 1'b0);
            @(negedge clk);
        end
        #1;
        check("w16.done", dn16, 1'b1);
        check("w16.done_frame", fr16, 1'b0);
        check("w16.done_tick", tk16, 1'b0);
        @(negedge clk);
        #1;
        check("w16.done_once", dn16, 1'b0);
        check("w16.ready_back", rdy16, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
